// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions for the load/store unit.
//   - funct3 encodings for loads and stores (the memory mode pin reuses the
//     load encoding)
//   - response fault codes
//   - access_fault(): classifies a request before any memory access
package load_store_unit_pkg;

  localparam logic [2:0] LOAD_BYTE          = 3'b000;
  localparam logic [2:0] LOAD_HALF          = 3'b001;
  localparam logic [2:0] LOAD_WORD          = 3'b010;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0] FAULT_INVALID    = 2'b10;

  // An illegal funct3 takes priority over alignment, since the access size
  // is meaningless for an encoding that does not exist. funct3[1:0] gives
  // the access size for every legal load and store encoding.
  function automatic logic [1:0] access_fault(input logic       write,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic       legal;
    logic [1:0] fault;
    if (write)
      legal = (funct3 == STORE_BYTE) || (funct3 == STORE_HALF) ||
              (funct3 == STORE_WORD);
    else
      legal = (funct3 == LOAD_BYTE) || (funct3 == LOAD_HALF) ||
              (funct3 == LOAD_WORD) || (funct3 == LOAD_BYTE_UNSIGNED) ||
              (funct3 == LOAD_HALF_UNSIGNED);
    fault = FAULT_NONE;
    if (!legal)
      fault = FAULT_INVALID;
    else if ((funct3[1:0] == 2'b01) && addr_lo[0])
      fault = FAULT_MISALIGNED;
    else if ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00))
      fault = FAULT_MISALIGNED;
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_store_merge.sv
// store_merge: combinational byte/half lane insertion for read-modify-write.
// Ports:
//   old_word    in  32  word currently held in memory
//   store_data  in  32  right-aligned store data
//   funct3      in  3   store funct3 (SB / SH / SW)
//   byte_offset in  2   low address bits selecting the lane
//   merged      out 32  word to write back
module store_merge
  import load_store_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (funct3)
      STORE_BYTE: merged[{byte_offset, 3'b000} +: 8] = store_data[7:0];
      STORE_HALF: begin
        if (byte_offset[1])
          merged[31:16] = store_data[15:0];
        else
          merged[15:0]  = store_data[15:0];
      end
      default:    merged = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between the
// execute stage and a word-organised data memory. Sub-word stores are done
// as read-modify-write because the memory only writes whole words.
// Ports:
//   i_Clock, i_Reset              clock, synchronous active-high reset
//   i_ReqValid / o_ReqReady       request handshake (ready only in IDLE)
//   i_ReqWrite, i_ReqFunct3       store flag and RISC-V funct3
//   i_ReqAddress, i_ReqStoreData  byte address, right-aligned store data
//   o_MemReadEnable/WriteEnable   memory strobes (never both high)
//   o_MemAddress, o_MemMode       memory byte address and load-mode
//   o_MemDataOut, i_MemDataIn     write word / combinational read data
//   o_RespValid                   one-cycle response pulse
//   o_RespData, o_RespFault       load result (0 otherwise), fault code
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_BITS = 15
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [2:0]  i_ReqFunct3,
  input  logic [31:0] i_ReqAddress,
  input  logic [31:0] i_ReqStoreData,
  output logic        o_MemReadEnable,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [2:0]  o_MemMode,
  output logic [31:0] o_MemDataOut,
  input  logic [31:0] i_MemDataIn,
  output logic        o_RespValid,
  output logic [31:0] o_RespData,
  output logic [1:0]  o_RespFault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [31:0] merged_q;
  logic [31:0] resp_data_q;
  logic [1:0]  fault_q;

  logic        accept;
  logic [1:0]  req_fault;
  logic [31:0] merge_word;
  logic [31:0] fwd_addr;
  logic [31:0] word_addr;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [2:0]  mem_mode;
  logic [31:0] mem_dout;

  assign accept    = i_ReqValid && (state == ST_IDLE);
  assign req_fault = access_fault(i_ReqWrite, i_ReqFunct3, i_ReqAddress[1:0]);

  // The memory decodes only the low ADDR_BITS; the upper bits are forwarded
  // untouched so the full request address remains visible on the pins.
  assign fwd_addr  = {addr_q[31:ADDR_BITS], addr_q[ADDR_BITS-1:0]};
  assign word_addr = {fwd_addr[31:2], 2'b00};

  store_merge u_store_merge (
    .old_word    (i_MemDataIn),
    .store_data  (store_data_q),
    .funct3      (funct3_q),
    .byte_offset (addr_q[1:0]),
    .merged      (merge_word)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Request and data registers carry no reset: every output that exposes
  // them is qualified by the state, which is reset.
  always_ff @(posedge i_Clock) begin
    if (accept) begin
      funct3_q     <= i_ReqFunct3;
      addr_q       <= i_ReqAddress;
      store_data_q <= i_ReqStoreData;
      fault_q      <= req_fault;
      resp_data_q  <= '0;
    end
    if (state == ST_LOAD)
      resp_data_q <= i_MemDataIn;
    if (state == ST_RMW_READ)
      merged_q <= merge_word;
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_mode   = '0;
    mem_dout   = '0;
    case (state)
      ST_IDLE: begin
        if (i_ReqValid) begin
          if (req_fault != FAULT_NONE)
            state_next = ST_RESP;
          else if (!i_ReqWrite)
            state_next = ST_LOAD;
          else if (i_ReqFunct3 == STORE_WORD)
            state_next = ST_WRITE;
          else
            state_next = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        mem_rd     = 1'b1;
        mem_addr   = fwd_addr;
        mem_mode   = funct3_q;
        state_next = ST_RESP;
      end
      ST_RMW_READ: begin
        mem_rd     = 1'b1;
        mem_addr   = word_addr;
        mem_mode   = LOAD_WORD;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr     = 1'b1;
        mem_addr   = word_addr;
        mem_dout   = (funct3_q == STORE_WORD) ? store_data_q : merged_q;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Strobes are gated by reset directly so a reset landing in WRITE cannot
  // commit a partial read-modify-write.
  assign o_MemReadEnable  = mem_rd && !i_Reset;
  assign o_MemWriteEnable = mem_wr && !i_Reset;
  assign o_MemAddress     = mem_addr;
  assign o_MemMode        = mem_mode;
  assign o_MemDataOut     = mem_dout;

  assign o_ReqReady  = (state == ST_IDLE);
  assign o_RespValid = (state == ST_RESP) && !i_Reset;
  assign o_RespData  = (state == ST_RESP) ? resp_data_q : '0;
  assign o_RespFault = (state == ST_RESP) ? fault_q : FAULT_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_ReqWrite;
  logic [2:0]  i_ReqFunct3;
  logic [31:0] i_ReqAddress;
  logic [31:0] i_ReqStoreData;
  logic        o_MemReadEnable;
  logic        o_MemWriteEnable;
  logic [31:0] o_MemAddress;
  logic [2:0]  o_MemMode;
  logic [31:0] o_MemDataOut;
  logic [31:0] i_MemDataIn;
  logic        o_RespValid;
  logic [31:0] o_RespData;
  logic [1:0]  o_RespFault;

  always #5 i_Clock = ~i_Clock;

  load_store_unit dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_ReqValid       (i_ReqValid),
    .o_ReqReady       (o_ReqReady),
    .i_ReqWrite       (i_ReqWrite),
    .i_ReqFunct3      (i_ReqFunct3),
    .i_ReqAddress     (i_ReqAddress),
    .i_ReqStoreData   (i_ReqStoreData),
    .o_MemReadEnable  (o_MemReadEnable),
    .o_MemWriteEnable (o_MemWriteEnable),
    .o_MemAddress     (o_MemAddress),
    .o_MemMode        (o_MemMode),
    .o_MemDataOut     (o_MemDataOut),
    .i_MemDataIn      (i_MemDataIn),
    .o_RespValid      (o_RespValid),
    .o_RespData       (o_RespData),
    .o_RespFault      (o_RespFault)
  );

  // Standalone store_merge instance for the lane-insertion table.
  logic [31:0] sm_old, sm_data, sm_out;
  logic [2:0]  sm_f3;
  logic [1:0]  sm_off;
  store_merge u_sm (
    .old_word    (sm_old),
    .store_data  (sm_data),
    .funct3      (sm_f3),
    .byte_offset (sm_off),
    .merged      (sm_out)
  );

  // Memory model: 1024 words, combinational read with mode extraction.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge i_Clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (o_MemWriteEnable) mem[o_MemAddress[11:2]] <= o_MemDataOut;
  end

  function automatic logic [31:0] mem_view(input logic [31:0] w, input logic [2:0] mode,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (mode)
      LOAD_BYTE:          return {{24{b[7]}}, b};
      LOAD_HALF:          return {{16{h[15]}}, h};
      LOAD_WORD:          return w;
      LOAD_BYTE_UNSIGNED: return {24'h0, b};
      LOAD_HALF_UNSIGNED: return {16'h0, h};
      default:            return 32'h0;
    endcase
  endfunction

  always_comb i_MemDataIn = mem_view(mem[o_MemAddress[11:2]], o_MemMode, o_MemAddress[1:0]);

  // Bus monitor, sampled on the falling edge.
  int          rd_cyc = 0, wr_cyc = 0, both_hi = 0, idle_dirty = 0, resp_cnt = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [2:0]  last_rd_mode = '0;

  always @(negedge i_Clock) begin
    if (o_MemReadEnable) begin
      rd_cyc       <= rd_cyc + 1;
      last_rd_addr <= o_MemAddress;
      last_rd_mode <= o_MemMode;
    end
    if (o_MemWriteEnable) begin
      wr_cyc       <= wr_cyc + 1;
      last_wr_addr <= o_MemAddress;
      last_wr_data <= o_MemDataOut;
    end
    if (o_MemReadEnable && o_MemWriteEnable) both_hi <= both_hi + 1;
    if (!o_MemReadEnable && !o_MemWriteEnable && !i_Reset &&
        (o_MemAddress != 0 || o_MemMode != 0 || o_MemDataOut != 0))
      idle_dirty <= idle_dirty + 1;
    if (o_RespValid) resp_cnt <= resp_cnt + 1;
  end

  int tests = 0;
  int fails = 0;
  int resp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level, arithmetic on a word array.
  logic [31:0] ref_mem [0:1023];

  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, output logic [1:0] fault,
                       output logic [31:0] rdata, output int lat, output int nrd,
                       output int nwr);
    int          size;
    int          sh;
    bit          legal;
    bit          sgn;
    logic [31:0] w, mask, v;
    size  = 1 << (f3 % 4);
    legal = wr ? (f3 <= 2) : (f3 != 3 && f3 != 6 && f3 != 7);
    sgn   = (f3 < 4);
    rdata = 0;
    nrd   = 0;
    nwr   = 0;
    if (!legal) begin
      fault = FAULT_INVALID;
      lat   = 1;
    end else if (addr % size != 0) begin
      fault = FAULT_MISALIGNED;
      lat   = 1;
    end else begin
      fault = FAULT_NONE;
      w     = ref_mem[addr[11:2]];
      sh    = 8 * (addr % 4);
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      if (!wr) begin
        v = (w >> sh) & mask;
        if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
        rdata = v;
        lat   = 2;
        nrd   = 1;
      end else begin
        ref_mem[addr[11:2]] = (w & ~(mask << sh)) | ((data & mask) << sh);
        lat = (size == 4) ? 2 : 3;
        nrd = (size == 4) ? 0 : 1;
        nwr = 1;
      end
    end
  endtask

  task automatic pre(input logic [31:0] addr, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = addr[11:2];
    pl_val = val;
    ref_mem[addr[11:2]] = val;
    @(posedge i_Clock); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request; returns wait cycles before accept, latency from the
  // accept edge to the response (0 on timeout), and the response fields.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output int wt, output int lat,
                         output logic [31:0] rdata, output logic [1:0] rfault);
    i_ReqValid     = 1'b1;
    i_ReqWrite     = wr;
    i_ReqFunct3    = f3;
    i_ReqAddress   = addr;
    i_ReqStoreData = data;
    wt = 0;
    while (!o_ReqReady && wt < 10) begin
      @(posedge i_Clock); #1;
      wt++;
    end
    @(posedge i_Clock); #1;
    i_ReqValid = 1'b0;
    lat    = 0;
    rdata  = '0;
    rfault = '0;
    for (int k = 1; k <= 6; k++) begin
      if (o_RespValid) begin
        lat    = k;
        rdata  = o_RespData;
        rfault = o_RespFault;
        resp_seen++;
        break;
      end
      @(posedge i_Clock); #1;
    end
  endtask

  typedef struct {
    logic [31:0] old_w;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } merge_vec_t;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } req_vec_t;

  initial begin
    merge_vec_t  mv[9];
    req_vec_t    bb[3];
    int          wt, lat, rd0, wr0, elat, enrd, enwr, idx, accepts, rn, viol, seen;
    logic [31:0] rdata, edata, addr, data;
    logic [1:0]  rfault, efault;
    logic [2:0]  f3;
    logic        wr, rdy;
    logic [31:0] bb_got[3];

    mv[0] = '{32'h11223344, 32'h0000005A, STORE_BYTE, 2'd3, 32'h5A223344};
    mv[1] = '{32'h11223344, 32'h0000005A, STORE_BYTE, 2'd0, 32'h1122335A};
    mv[2] = '{32'h11223344, 32'h0000005A, STORE_BYTE, 2'd1, 32'h11225A44};
    mv[3] = '{32'h11223344, 32'h0000005A, STORE_BYTE, 2'd2, 32'h115A3344};
    mv[4] = '{32'h11223344, 32'h0000BEEF, STORE_HALF, 2'd2, 32'hBEEF3344};
    mv[5] = '{32'h11223344, 32'h0000BEEF, STORE_HALF, 2'd0, 32'h1122BEEF};
    mv[6] = '{32'h11223344, 32'hCAFEF00D, STORE_WORD, 2'd0, 32'hCAFEF00D};
    mv[7] = '{32'h00000000, 32'hFFFFFFAB, STORE_BYTE, 2'd1, 32'h0000AB00};
    mv[8] = '{32'hFFFFFFFF, 32'h1234ABCD, STORE_HALF, 2'd0, 32'hFFFFABCD};

    bb[0] = '{1'b0, LOAD_WORD,          32'h300, 32'h0,        32'h8BADF00D};
    bb[1] = '{1'b1, STORE_WORD,         32'h304, 32'h12345678, 32'h0};
    bb[2] = '{1'b0, LOAD_BYTE_UNSIGNED, 32'h306, 32'h0,        32'h00000034};

    i_Reset = 1'b1; i_ReqValid = 1'b0; i_ReqWrite = 1'b0; i_ReqFunct3 = '0;
    i_ReqAddress = '0; i_ReqStoreData = '0;
    @(posedge i_Clock); #1;

    // Memory fill happens while the unit is held in reset.
    for (int i = 0; i < 1024; i++) pre(32'(i * 4), $urandom);
    check("rst_rd_en", o_MemReadEnable, 0);
    check("rst_wr_en", o_MemWriteEnable, 0);
    check("rst_resp_valid", o_RespValid, 0);
    i_Reset = 1'b0;
    #1;
    check("rst_ready", o_ReqReady, 1);
    check("rst_addr", o_MemAddress, 0);
    check("rst_mode", o_MemMode, 0);
    check("rst_dout", o_MemDataOut, 0);
    check("rst_resp_data", o_RespData, 0);
    check("rst_resp_fault", o_RespFault, 0);

    for (int i = 0; i < 9; i++) begin
      sm_old = mv[i].old_w; sm_data = mv[i].data; sm_f3 = mv[i].f3; sm_off = mv[i].off;
      #1;
      check($sformatf("merge_vec%0d", i), sm_out, mv[i].exp);
    end

    // LW at 0x100
    pre(32'h100, 32'hDEADBEEF);
    rd0 = rd_cyc; wr0 = wr_cyc;
    run_req(1'b0, LOAD_WORD, 32'h100, 32'h0, wt, lat, rdata, rfault);
    check("lw_latency", lat, 2);
    check("lw_data", rdata, 32'hDEADBEEF);
    check("lw_fault", rfault, FAULT_NONE);
    check("lw_rd_cycles", rd_cyc - rd0, 1);
    check("lw_wr_cycles", wr_cyc - wr0, 0);
    check("lw_rd_addr", last_rd_addr, 32'h100);
    check("lw_rd_mode", last_rd_mode, LOAD_WORD);

    // SB 0x5A at 0x203
    pre(32'h200, 32'h11223344);
    rd0 = rd_cyc; wr0 = wr_cyc;
    run_req(1'b1, STORE_BYTE, 32'h203, 32'h0000005A, wt, lat, rdata, rfault);
    check("sb_latency", lat, 3);
    check("sb_resp_data", rdata, 0);
    check("sb_fault", rfault, FAULT_NONE);
    check("sb_rd_cycles", rd_cyc - rd0, 1);
    check("sb_wr_cycles", wr_cyc - wr0, 1);
    check("sb_rd_addr", last_rd_addr, 32'h200);
    check("sb_rd_mode", last_rd_mode, LOAD_WORD);
    check("sb_wr_addr", last_wr_addr, 32'h200);
    check("sb_wr_data", last_wr_data, 32'h5A223344);
    check("sb_mem", mem[32'h200 >> 2], 32'h5A223344);

    // SH 0xBEEF at 0x202, then misaligned SH at 0x201
    pre(32'h200, 32'h11223344);
    run_req(1'b1, STORE_HALF, 32'h202, 32'h0000BEEF, wt, lat, rdata, rfault);
    check("sh_latency", lat, 3);
    check("sh_mem", mem[32'h200 >> 2], 32'hBEEF3344);
    rd0 = rd_cyc; wr0 = wr_cyc;
    run_req(1'b1, STORE_HALF, 32'h201, 32'h0000BEEF, wt, lat, rdata, rfault);
    check("sh_mis_latency", lat, 1);
    check("sh_mis_fault", rfault, FAULT_MISALIGNED);
    check("sh_mis_rd_cycles", rd_cyc - rd0, 0);
    check("sh_mis_wr_cycles", wr_cyc - wr0, 0);
    check("sh_mis_mem", mem[32'h200 >> 2], 32'hBEEF3344);

    // Invalid load funct3, then SW right behind it
    rd0 = rd_cyc; wr0 = wr_cyc;
    run_req(1'b0, 3'b011, 32'h100, 32'h0, wt, lat, rdata, rfault);
    check("inv_latency", lat, 1);
    check("inv_fault", rfault, FAULT_INVALID);
    check("inv_data", rdata, 0);
    check("inv_rd_cycles", rd_cyc - rd0, 0);
    run_req(1'b1, STORE_WORD, 32'h10, 32'hCAFEF00D, wt, lat, rdata, rfault);
    check("sw_wait", wt, 1);
    check("sw_latency", lat, 2);
    check("sw_rd_cycles", rd_cyc - rd0, 0);
    check("sw_wr_cycles", wr_cyc - wr0, 1);
    check("sw_wr_addr", last_wr_addr, 32'h10);
    check("sw_wr_data", last_wr_data, 32'hCAFEF00D);
    check("sw_mem", mem[32'h10 >> 2], 32'hCAFEF00D);

    // Reset during the WRITE cycle of an SB
    pre(32'h400, 32'h11223344);
    rd0 = rd_cyc; wr0 = wr_cyc;
    i_ReqValid = 1'b1; i_ReqWrite = 1'b1; i_ReqFunct3 = STORE_BYTE;
    i_ReqAddress = 32'h401; i_ReqStoreData = 32'h77;
    @(posedge i_Clock); #1;
    i_ReqValid = 1'b0;
    check("rstw_ready_busy", o_ReqReady, 0);
    @(posedge i_Clock); #1;
    check("rstw_wen_before", o_MemWriteEnable, 1);
    i_Reset = 1'b1;
    #1;
    check("rstw_wen_gated", o_MemWriteEnable, 0);
    @(posedge i_Clock); #1;
    i_Reset = 1'b0;
    #1;
    check("rstw_ready_after", o_ReqReady, 1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_RespValid) seen++;
      @(posedge i_Clock); #1;
    end
    check("rstw_no_resp", seen, 0);
    check("rstw_mem", mem[32'h400 >> 2], 32'h11223344);
    check("rstw_rd_cycles", rd_cyc - rd0, 1);
    check("rstw_wr_cycles", wr_cyc - wr0, 0);

    // Back-to-back LW / SW / LBU with valid held high
    pre(32'h300, 32'h8BADF00D);
    idx = 0; accepts = 0; rn = 0; viol = 0;
    i_ReqValid = 1'b1; i_ReqWrite = bb[0].wr; i_ReqFunct3 = bb[0].f3;
    i_ReqAddress = bb[0].addr; i_ReqStoreData = bb[0].data;
    for (int cyc = 0; cyc < 40 && rn < 3; cyc++) begin
      rdy = o_ReqReady;
      if (accepts > rn && rdy) viol++;
      @(posedge i_Clock); #1;
      if (rdy && i_ReqValid) begin
        accepts++;
        idx++;
        if (idx < 3) begin
          i_ReqWrite = bb[idx].wr; i_ReqFunct3 = bb[idx].f3;
          i_ReqAddress = bb[idx].addr; i_ReqStoreData = bb[idx].data;
        end else begin
          i_ReqValid = 1'b0;
        end
      end
      if (o_RespValid) begin
        bb_got[rn] = o_RespData;
        rn++;
        resp_seen++;
      end
    end
    i_ReqValid = 1'b0;
    check("b2b_accepts", accepts, 3);
    check("b2b_responses", rn, 3);
    check("b2b_ready_while_busy", viol, 0);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_data%0d", i), (i < rn) ? bb_got[i] : 32'hXXXXXXXX, bb[i].exp);
    check("b2b_sw_mem", mem[32'h304 >> 2], 32'h12345678);

    // Randomised traffic against the reference model
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom_range(0, 1));
      if (wr && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      data = $urandom;
      model(wr, f3, addr, data, efault, edata, elat, enrd, enwr);
      rd0 = rd_cyc; wr0 = wr_cyc;
      run_req(wr, f3, addr, data, wt, lat, rdata, rfault);
      check("rand_fault", rfault, efault);
      check("rand_data", rdata, edata);
      check("rand_latency", lat, elat);
      check("rand_rd_cycles", rd_cyc - rd0, enrd);
      check("rand_wr_cycles", wr_cyc - wr0, enwr);
      if (wr) check("rand_mem", mem[addr[11:2]], ref_mem[addr[11:2]]);
    end

    repeat (3) @(posedge i_Clock);
    #1;
    check("both_enables_high", both_hi, 0);
    check("idle_outputs_nonzero", idle_dirty, 0);
    check("resp_pulse_total", resp_cnt, resp_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
